// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
//   state_e  : arbiter FSM states
//   owner_e  : which requester currently owns the memory port
//   arbitrate: fixed-priority pick, D over I
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Instruction fetches are always full 32-bit words.
  localparam logic [2:0] FETCH_CTRL = 3'b010;

  function automatic owner_e arbitrate(input logic d_req, input logic i_req);
    if (d_req)      return OWN_D;
    else if (i_req) return OWN_I;
    else            return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state timer for the arbiter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count at zero (has priority over en)
//   en       : count one cycle
//   expire   : count has reached TIMEOUT-1
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One transaction outstanding at a time, D has fixed priority, and a
// wait-state timeout completes the access with err instead of hanging.
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (held until if_valid)
//   if_valid/if_rdata             : registered fetch completion pulse + word
//   d_req/d_we/d_addr/d_wdata/d_ctrl : data request (held until d_valid)
//   d_valid/d_rdata               : registered data completion pulse + data
//   err                           : pulses with the valid of a timed-out access
//   mem_req/we/addr/wdata/ctrl    : memory request, combinational from owner
//   mem_ready/mem_rvalid/mem_rdata: memory accept, response, response data
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_valid,
  output logic [31:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [2:0]       d_ctrl,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_ctrl,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             if_valid_q, if_valid_d;
  logic             d_valid_q, d_valid_d;
  logic             err_q, err_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             expire;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ISSUE && mem_ready),
    .en     (state_q == WAIT),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        owner_d = arbitrate(d_req, if_req);
        if (owner_d != OWN_NONE) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        // A response in the expiry cycle still counts as success.
        if (mem_rvalid) begin
          // The completing requester still holds req this cycle, so it is
          // masked out of the immediate re-arbitration.
          if (owner_q == OWN_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_rdata;
            owner_d   = arbitrate(1'b0, if_req);
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata[31:0];
            owner_d    = arbitrate(d_req, 1'b0);
          end
          state_d = (owner_d == OWN_NONE) ? IDLE : ISSUE;
        end else if (expire) begin
          err_d = 1'b1;
          if (owner_q == OWN_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_valid  = d_valid_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;

  // Request fields follow the latched owner; the requester keeps them stable.
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_req && (owner_q == OWN_D) && d_we;
  assign mem_addr  = (owner_q == OWN_D) ? d_addr :
                     (owner_q == OWN_I) ? if_addr : '0;
  assign mem_wdata = (owner_q == OWN_D) ? d_wdata : '0;
  assign mem_ctrl  = (owner_q == OWN_D) ? d_ctrl :
                     (owner_q == OWN_I) ? FETCH_CTRL : 3'b000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_valid;
  logic [31:0]      if_rdata;
  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [2:0]       d_ctrl;
  logic             d_valid;
  logic [WIDTH-1:0] d_rdata;
  logic             err;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [2:0]       mem_ctrl;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ctrl(d_ctrl),
    .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [63:0] rdata, input logic e);
    exp_t x;
    x.is_d = is_d; x.rdata = rdata; x.err = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_valid || d_valid) begin
      chk(64'(sb.size() != 0), 64'd1, "sb_pulse_expected");
      chk(64'(if_valid & d_valid), 64'd0, "sb_single_pulse");
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(64'(d_valid), 64'(e.is_d), "sb_owner");
        chk(d_valid ? d_rdata : {32'b0, if_rdata}, e.rdata, "sb_rdata");
        chk(64'(err), 64'(e.err), "sb_err");
      end
    end else if (err) begin
      chk(64'(err), 64'd0, "err_without_valid");
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_issue(input string tag);
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    chk(64'(mem_req), 64'd1, tag);
  endtask

  // Accept the pending request, then respond 'delay' cycles after accept.
  // Returns at the negedge where the completion pulse is visible.
  task automatic respond(input logic [63:0] data, input int delay);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (delay - 1) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_ctrl = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    cyc(3);
    chk(64'(mem_req), 0, "rst_mem_req");
    chk(64'(mem_we), 0, "rst_mem_we");
    chk(64'(if_valid), 0, "rst_if_valid");
    chk(64'(d_valid), 0, "rst_d_valid");
    chk(64'(err), 0, "rst_err");
    chk({32'b0, if_rdata}, 0, "rst_if_rdata");
    chk(d_rdata, 0, "rst_d_rdata");
    rst = 1'b0;
    cyc(1);

    // 1: fetch only
    if_req = 1; if_addr = 64'h40;
    push(1'b0, 64'h00500093, 1'b0);
    wait_issue("t1_issue");
    chk(mem_addr, 64'h40, "t1_addr");
    chk(64'(mem_ctrl), 64'(3'b010), "t1_ctrl");
    chk(64'(mem_we), 0, "t1_we");
    respond(64'h00500093, 2);
    chk(64'(if_valid), 1, "t1_valid");
    chk(64'(mem_req), 0, "t1_no_reissue");
    if_req = 0;
    cyc(1);
    chk(64'(if_valid), 0, "t1_single_pulse");

    // 2: simultaneous requests, D first, I issued back-to-back
    if_req = 1; if_addr = 64'h44;
    d_req = 1; d_we = 0; d_addr = 64'h1000; d_ctrl = 3'b011;
    push(1'b1, 64'h1122334455667788, 1'b0);
    push(1'b0, 64'h0000000000000013, 1'b0);
    wait_issue("t2_issue_d");
    chk(mem_addr, 64'h1000, "t2_d_addr");
    chk(64'(mem_ctrl), 64'(3'b011), "t2_d_ctrl");
    respond(64'h1122334455667788, 1);
    chk(64'(d_valid), 1, "t2_d_valid");
    chk(64'(mem_req), 1, "t2_i_no_bubble");
    chk(mem_addr, 64'h44, "t2_i_addr");
    chk(64'(mem_ctrl), 64'(3'b010), "t2_i_ctrl");
    d_req = 0;
    respond(64'hFFFFFFFF00000013, 1);
    chk(64'(if_valid), 1, "t2_i_valid");
    if_req = 0;
    cyc(1);

    // 3: store; d_req still high on the ack cycle must not be re-issued
    d_req = 1; d_we = 1; d_addr = 64'h2008; d_wdata = 64'hDEADBEEF; d_ctrl = 3'b011;
    push(1'b1, 64'h0, 1'b0);
    wait_issue("t3_issue");
    chk(64'(mem_we), 1, "t3_we");
    chk(mem_addr, 64'h2008, "t3_addr");
    chk(mem_wdata, 64'hDEADBEEF, "t3_wdata");
    chk(64'(mem_ctrl), 64'(3'b011), "t3_ctrl");
    respond(64'h0, 2);
    chk(64'(d_valid), 1, "t3_valid");
    chk(64'(mem_req), 0, "t3_excluded");
    d_req = 0; d_we = 0;
    cyc(1);
    chk(64'(mem_req), 0, "t3_idle");

    // 4: stall on mem_ready; request held stable
    if_req = 1; if_addr = 64'h80;
    push(1'b0, 64'h00100073, 1'b0);
    wait_issue("t4_issue");
    for (int k = 0; k < 5; k++) begin
      chk(64'(mem_req), 1, "t4_held");
      chk(mem_addr, 64'h80, "t4_addr");
      cyc(1);
    end
    respond(64'h00100073, 3);
    chk(64'(if_valid), 1, "t4_valid");
    if_req = 0;
    cyc(1);

    // 5: timeout exactly TIMEOUT cycles after accept, late rvalid ignored
    d_req = 1; d_we = 0; d_addr = 64'h3000; d_ctrl = 3'b011;
    push(1'b1, 64'h0, 1'b1);
    wait_issue("t5_issue");
    mem_ready = 1;
    cyc(1);
    mem_ready = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      chk(64'(d_valid | err), 0, "t5_early");
      cyc(1);
    end
    chk(64'(d_valid), 1, "t5_valid");
    chk(64'(err), 1, "t5_err");
    d_req = 0;
    cyc(3);
    mem_rvalid = 1; mem_rdata = 64'h55;
    cyc(1);
    mem_rvalid = 0; mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      chk(64'(d_valid | if_valid | err), 0, "t5_late_ignored");
      cyc(1);
    end

    // 6: reset in WAIT kills the access; held d_req re-issued afterwards
    d_req = 1; d_addr = 64'h4000;
    push(1'b1, 64'hABCD, 1'b0);
    wait_issue("t6_issue");
    mem_ready = 1;
    cyc(1);
    mem_ready = 0;
    cyc(2);
    rst = 1;
    cyc(1);
    chk(64'(mem_req), 0, "t6_rst_mem_req");
    chk(64'(d_valid | if_valid | err), 0, "t6_rst_no_valid");
    rst = 0;
    cyc(1);
    chk(64'(mem_req), 1, "t6_reissue");
    chk(mem_addr, 64'h4000, "t6_addr");
    respond(64'hABCD, 1);
    chk(64'(d_valid), 1, "t6_valid");
    d_req = 0;
    cyc(1);

    // 7: rvalid in the expiry cycle counts as success
    d_req = 1; d_addr = 64'h5000;
    push(1'b1, 64'hCAFE, 1'b0);
    wait_issue("t7_issue");
    respond(64'hCAFE, TIMEOUT);
    chk(64'(d_valid), 1, "t7_valid");
    chk(64'(err), 0, "t7_no_err");
    d_req = 0;
    cyc(3);

    chk(64'(sb.size()), 0, "sb_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
